// File: rtl/sonic_st_pkg.sv
// Shared definitions for the sonic Avalon-ST adapters: ready-latency limit,
// default payload width and the width helper used to size counters and pointers.
package sonic_st_pkg;

    localparam int ST_MAX_RL = 4;
    localparam int ST_DATA_W = 72;

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sonic_st_sync_fifo.sv
// Single-clock FIFO with explicit pointer wrap, so DEPTH may be any value >= 2.
// Head entry is read combinationally; storage itself is never reset.
module sonic_st_sync_fifo
    import sonic_st_pkg::*;
#(
    parameter  int DATA_W = ST_DATA_W,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [DATA_W-1:0] head_data_o
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign do_rd = pop_i && !empty_o;
    assign do_wr = push_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sonic_st_timing_adapter_rl.sv
// Avalon-ST timing adapter: upstream ready latency IN_RL to downstream latency 0,
// absorbing in-flight beats in a FIFO and accounting for any beats it had to drop.
module sonic_st_timing_adapter_rl
    import sonic_st_pkg::*;
#(
    parameter  int DATA_W     = ST_DATA_W,
    parameter  int IN_RL      = 1,
    parameter  int DEPTH      = 8,
    parameter  int DROP_CNT_W = 16,
    localparam int CNT_W      = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0]      fill_level
);

    if (IN_RL > ST_MAX_RL) begin : g_bad_rl
        $error("sonic_st_timing_adapter_rl: IN_RL=%0d exceeds %0d", IN_RL, ST_MAX_RL);
    end
    if (DEPTH < IN_RL + 2) begin : g_bad_depth
        $error("sonic_st_timing_adapter_rl: DEPTH=%0d below IN_RL+2", DEPTH);
    end

    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      count;
    logic                  pop, wr_ok, drop;
    logic [CNT_W-1:0]      count_next;
    logic                  in_ready_q, in_ready_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    sonic_st_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (in_valid),
        .pop_i       (pop),
        .wr_data_i   (in_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count),
        .head_data_o (out_data)
    );

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign wr_ok      = in_valid && (!fifo_full || pop);
    assign drop       = in_valid && fifo_full && !pop;
    assign in_ready   = in_ready_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
    assign fill_level = count;

    // Ready deasserts early enough that IN_RL beats already in flight still fit.
    always_comb begin
        count_next = count;
        case ({wr_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        in_ready_d = (count_next <= CNT_W'(DEPTH - 1 - IN_RL));
        overflow_d = overflow_q || drop;
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
